// File: rtl/alu4_arbiter.sv
// Round-robin scheduler sharing one external 4-bit ALU between N_REQ clients.
// Define ALU4_ARBITER_ZERO_FLAG_EN to add the registered rsp_zero output.
module alu4_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [4*N_REQ-1:0]   req_a,
  input  logic [4*N_REQ-1:0]   req_b,
  input  logic [3*N_REQ-1:0]   req_sel,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [2:0]           alu_sel,
  input  logic [3:0]           alu_y,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [3:0]           rsp_data,
  output logic [ID_W-1:0]      rsp_id,
`ifdef ALU4_ARBITER_ZERO_FLAG_EN
  output logic                 rsp_zero,
`endif
  output logic                 busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  win;
  logic             found;
  logic [3:0]       win_a;
  logic [3:0]       win_b;
  logic [2:0]       win_sel;
  int               idx;

  // Search starts at rr_ptr so the last-served client ranks lowest.
  always_comb begin
    grant   = '0;
    win     = '0;
    found   = 1'b0;
    idx     = 0;
    win_a   = '0;
    win_b   = '0;
    win_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = ID_W'(idx);
        win_a      = req_a[idx*4 +: 4];
        win_b      = req_b[idx*4 +: 4];
        win_sel    = req_sel[idx*3 +: 3];
      end
    end
  end

  // Gate with rst_n so no grant is advertised while reset is held.
  assign req_ready = (rst_n && state == IDLE) ? grant : '0;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
`ifdef ALU4_ARBITER_ZERO_FLAG_EN
      rsp_zero <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            alu_a   <= win_a;
            alu_b   <= win_b;
            alu_sel <= win_sel;
            rsp_id  <= win;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_data <= alu_y;
`ifdef ALU4_ARBITER_ZERO_FLAG_EN
          rsp_zero <= (alu_y == 4'b0000);
`endif
          state    <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            if (rsp_id == ID_W'(N_REQ-1))
              rr_ptr <= '0;
            else
              rr_ptr <= rsp_id + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu4_arbiter.sv
// Directed self-checking bench for alu4_arbiter with a small external ALU.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu4_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [11:0] req_sel;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [2:0]  alu_sel;
  logic [3:0]  alu_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;
`ifdef ALU4_ARBITER_ZERO_FLAG_EN
  logic        rsp_zero;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu4_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_y     (alu_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
`ifdef ALU4_ARBITER_ZERO_FLAG_EN
    .rsp_zero  (rsp_zero),
`endif
    .busy      (busy)
  );

  // External ALU; unknown codes pass operand A.
  always_comb begin
    case (alu_sel)
      3'd0:    alu_y = alu_a + alu_b;
      3'd1:    alu_y = alu_a - alu_b;
      3'd2:    alu_y = alu_a & alu_b;
      3'd3:    alu_y = alu_a | alu_b;
      3'd4:    alu_y = alu_a ^ alu_b;
      default: alu_y = alu_a;
    endcase
  end

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    rsp_ready = 1'b0;
    nclk();
    nclk();
    chk("rst_valid", 8'(rsp_valid), 8'h0);
    chk("rst_busy",  8'(busy),      8'h0);
    chk("rst_ready", 8'(req_ready), 8'h0);
    chk("rst_alu_a", 8'(alu_a),     8'h0);
    chk("rst_sel",   8'(alu_sel),   8'h0);
    chk("rst_data",  8'(rsp_data),  8'h0);
    chk("rst_id",    8'(rsp_id),    8'h0);
`ifdef ALU4_ARBITER_ZERO_FLAG_EN
    chk("rst_zero",  8'(rsp_zero),  8'h0);
`endif
    rst_n = 1'b1;
    nclk();

    // Single request from client 0: 3 + 4 = 7.
    req_valid = 4'b0001;
    req_a     = 16'h0003;
    req_b     = 16'h0004;
    req_sel   = 12'h000;
    #1;
    chk("t1_ready", 8'(req_ready), 8'h01);
    nclk();
    req_valid = '0;
    chk("t1_exec_busy",  8'(busy),      8'h1);
    chk("t1_exec_valid", 8'(rsp_valid), 8'h0);
    chk("t1_exec_ready", 8'(req_ready), 8'h0);
    chk("t1_alu_a",      8'(alu_a),     8'h3);
    chk("t1_alu_b",      8'(alu_b),     8'h4);
    nclk();
    chk("t1_rsp_valid", 8'(rsp_valid), 8'h1);
    chk("t1_rsp_data",  8'(rsp_data),  8'h7);
    chk("t1_rsp_id",    8'(rsp_id),    8'h0);
    rsp_ready = 1'b1;
    nclk();
    chk("t1_done_valid", 8'(rsp_valid), 8'h0);
    chk("t1_done_busy",  8'(busy),      8'h0);

    // Client 2: 7 + 9 wraps to 0.
    req_valid = 4'b0100;
    req_a     = 16'h0700;
    req_b     = 16'h0900;
    req_sel   = 12'h000;
    #1;
    chk("t2_ready", 8'(req_ready), 8'h04);
    nclk();
    req_valid = '0;
    nclk();
    chk("t2_rsp_data", 8'(rsp_data), 8'h0);
    chk("t2_rsp_id",   8'(rsp_id),   8'h2);
`ifdef ALU4_ARBITER_ZERO_FLAG_EN
    chk("t2_rsp_zero", 8'(rsp_zero), 8'h1);
`endif
    nclk();

    // Fresh pointer, then all four valid: client i computes (i+1)+2.
    rst_n = 1'b0;
    nclk();
    rst_n     = 1'b1;
    req_a     = 16'h4321;
    req_b     = 16'h2222;
    req_sel   = 12'h000;
    req_valid = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      #1;
      chk("rr_grant", 8'(req_ready), 8'(1 << (r % 4)));
      nclk();
      chk("rr_exec_ready", 8'(req_ready), 8'h0);
      nclk();
      chk("rr_rsp_valid", 8'(rsp_valid), 8'h1);
      chk("rr_rsp_id",    8'(rsp_id),    8'(r % 4));
      chk("rr_rsp_data",  8'(rsp_data),  8'((r % 4) + 3));
      nclk();
    end
    req_valid = '0;

    // Backpressure: client 0 served (12 & 10 = 8) while client 1 waits.
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    req_a     = 16'h005C;
    req_b     = 16'h003A;
    req_sel   = 12'h00A;
    #1;
    chk("bp_grant0", 8'(req_ready), 8'h01);
    nclk();
    req_valid = 4'b0010;
    nclk();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 8'(rsp_valid), 8'h1);
      chk("bp_data",  8'(rsp_data),  8'h8);
      chk("bp_id",    8'(rsp_id),    8'h0);
      chk("bp_ready", 8'(req_ready), 8'h0);
      chk("bp_alu_a", 8'(alu_a),     8'hC);
      nclk();
    end
    rsp_ready = 1'b1;
    nclk();
    chk("bp_grant1", 8'(req_ready), 8'h02);
    nclk();
    req_valid = '0;
    chk("bp_alu_a1",   8'(alu_a),   8'h5);
    chk("bp_alu_sel1", 8'(alu_sel), 8'h1);
    nclk();
    chk("bp_rsp_data1", 8'(rsp_data), 8'h2);
    chk("bp_rsp_id1",   8'(rsp_id),   8'h1);
    nclk();

    // Serve client 3 (1 | 1 = 1), then 0 and 3 contend.
    req_valid = 4'b1000;
    req_a     = 16'h1006;
    req_b     = 16'h1001;
    req_sel   = 12'h607;
    #1;
    chk("pr_grant3", 8'(req_ready), 8'h08);
    nclk();
    req_valid = '0;
    nclk();
    chk("pr_rsp_data3", 8'(rsp_data), 8'h1);
    chk("pr_rsp_id3",   8'(rsp_id),   8'h3);
    nclk();
    req_valid = 4'b1001;
    #1;
    chk("pr_grant0", 8'(req_ready), 8'h01);
    nclk();
    chk("pr_sel_pass", 8'(alu_sel), 8'h7);
    nclk();
    chk("pr_rsp_data0", 8'(rsp_data), 8'h6);
    chk("pr_rsp_id0",   8'(rsp_id),   8'h0);
    nclk();
    #1;
    chk("pr_grant3b", 8'(req_ready), 8'h08);
    rsp_ready = 1'b0;
    nclk();
    nclk();
    chk("ar_pre_valid", 8'(rsp_valid), 8'h1);

    // Async reset while holding a response.
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 8'(rsp_valid), 8'h0);
    chk("ar_busy",  8'(busy),      8'h0);
    chk("ar_ready", 8'(req_ready), 8'h0);
    chk("ar_data",  8'(rsp_data),  8'h0);
    nclk();
    rst_n = 1'b1;
    #1;
    chk("ar_grant0", 8'(req_ready), 8'h01);
    nclk();
    req_valid = '0;
    nclk();
    chk("ar_rsp_id", 8'(rsp_id), 8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu4_arbiter.md
Name: alu4_arbiter

Overview:
- Round-robin scheduler that shares one 4-bit combinational ALU between N_REQ requesters.
- Accepts one operation at a time over a valid/ready handshake and drives the ALU operand/select inputs from registered copies.
- Captures the ALU result and returns it with the winning requester's ID over a response valid/ready handshake.
- Sits between client blocks and a single ALU instance; the ALU itself is external, connected through the alu_* ports.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of requester ID; must satisfy 2**ID_W >= N_REQ.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  N_REQ  bit i: requester i presents an operation.
- req_ready  out  N_REQ  bit i: operation of requester i accepted this cycle.
- req_a  in  4*N_REQ  operand A; requester i uses bits [4i+3:4i].
- req_b  in  4*N_REQ  operand B; requester i uses bits [4i+3:4i].
- req_sel  in  3*N_REQ  ALU select code; requester i uses bits [3i+2:3i].
- alu_a  out  4  registered operand A to the ALU.
- alu_b  out  4  registered operand B to the ALU.
- alu_sel  out  3  registered select to the ALU.
- alu_y  in  4  ALU result, combinational from alu_a/alu_b/alu_sel.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  4  captured result.
- rsp_id  out  ID_W  index of the requester that owns the response.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, rr_ptr=0.
  - alu_a/alu_b/alu_sel=0, rsp_data=0, rsp_id=0.
  - rsp_valid=0, req_ready=0, busy=0.
  - Reset mid-operation abandons the in-flight operation; no response is issued for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Arbitration is combinational: the winner is the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo N_REQ.
  - req_ready[winner]=1 in the same cycle; all other req_ready bits are 0.
  - On the clock edge: latch the winner's a/b/sel into alu_a/alu_b/alu_sel, latch the winner index into rsp_id, go to EXEC.
  - No valid request: stay in IDLE; all req_ready=0.
- EXEC (exactly 1 cycle): rsp_data <= alu_y; go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_valid && rsp_ready: rr_ptr <= (rsp_id+1) mod N_REQ; go to IDLE.
  - Otherwise hold. rsp_data, rsp_id and alu_* stay stable while rsp_valid=1 and rsp_ready=0.
- req_ready is 0 in EXEC and RESP. Requests arriving then wait; requesters must hold valid and payload until ready.
- Timing:
  - Accept at edge T, rsp_valid=1 from T+2.
  - Minimum initiation interval is 3 cycles when rsp_ready is tied high; the first IDLE cycle after a response can accept a new request.
- Fairness:
  - The requester just served has lowest priority next round.
  - With all N_REQ continuously valid, grants cycle 0,1,...,N_REQ-1,0.
- Results are 4 bits; overflow wraps as produced by the ALU. The arbiter does no arithmetic on data.
- req_valid dropping for a non-granted requester has no effect.
- Undefined select codes pass through unchanged.

Optional Feature:
- Macro: ALU4_ARBITER_ZERO_FLAG_EN.
- Defined:
  - Extra output rsp_zero (1 bit), registered in EXEC as (alu_y==4'b0000).
  - Stable alongside rsp_data; reset value 0.
- Undefined: port and register absent; all other behaviour identical.

Test Plan:
- Reset then single request: req0 a=3 b=4 sel=000 → req_ready[0] high in the accept cycle; rsp_valid 2 cycles later; rsp_data=7, rsp_id=0.
- Wrap: req2 a=7 b=9 sel=000 → rsp_data=0, rsp_id=2; with ALU4_ARBITER_ZERO_FLAG_EN, rsp_zero=1.
- Round-robin: all four valid continuously, rsp_ready=1 → rsp_id sequence 0,1,2,3,0; one accept per 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid with req1 valid → rsp_data/rsp_id stable, req_ready=0 throughout; req1 accepted the cycle after rsp_ready rises and the handshake completes.
- Priority after service: serve req3, then req0 and req3 both valid → req0 granted first.
- Async reset in RESP: rst_n low mid-cycle → rsp_valid, busy, req_ready drop immediately; after release, next grant starts from req0.
